// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp -- multi-ported register file with a per-register pending
// scoreboard.
//
// Purpose:
//   2**ADDR_W registers of DATA_W bits. Reads are combinational, with optional
//   same-cycle forwarding of write data. Writes are synchronous. Register 0 can
//   be hardwired to zero. A one-bit-per-register scoreboard tracks outstanding
//   writes: an issue sets a bit, a write clears it, and flush clears every bit.
//
// Ports:
//   clk        : single clock; all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   rd_addr    : NUM_RD*ADDR_W read addresses; port i uses slice i
//   rd_data    : NUM_RD*DATA_W read data; port i uses slice i
//   rd_pending : NUM_RD pending flags, one per read port
//   wr_en      : NUM_WR per-port write enables
//   wr_addr    : NUM_WR*ADDR_W write addresses
//   wr_data    : NUM_WR*DATA_W write data
//   iss_en     : mark iss_addr as pending
//   iss_addr   : ADDR_W register to mark
//   flush      : clear all pending bits
//   busy_any   : OR of all pending bits
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
   input  logic [NUM_WR*DATA_W-1:0] wr_data,
   input  logic                     iss_en,
   input  logic [ADDR_W-1:0]        iss_addr,
   input  logic                     flush,
   output logic                     busy_any
);

   localparam int DEPTH = 1 << ADDR_W;

   // Flattened views of the per-register state, gathered from the
   // per-register generate blocks below.
   logic [DATA_W-1:0] mem_words [DEPTH];
   logic [DEPTH-1:0]  pend_all;

   // -----------------------------------------------------------------------
   // Per-register storage and scoreboard bit
   // -----------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_reg
         logic              wr_hit;
         logic [DATA_W-1:0] wr_val;
         logic              iss_hit;
         logic              pend_next;
         logic [DATA_W-1:0] data_reg;
         logic              pend_reg;

         // Ports are scanned in ascending order so the highest-indexed
         // enabled port targeting this register supplies the data.
         always_comb begin
            wr_hit = 1'b0;
            wr_val = '0;
            for (int j = 0; j < NUM_WR; j++) begin
               if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(gi))) begin
                  wr_hit = 1'b1;
                  wr_val = wr_data[j*DATA_W +: DATA_W];
               end
            end
            // Register 0 never takes writes or issues when hardwired.
            if ((ZERO_REG != 0) && (gi == 0)) begin
               wr_hit = 1'b0;
            end
         end

         assign iss_hit = iss_en && (iss_addr == ADDR_W'(gi)) &&
                          !((ZERO_REG != 0) && (gi == 0));

         // Priority: issue set > flush / write clear > hold.
         always_comb begin
            pend_next = pend_reg;
            if (flush || wr_hit) begin
               pend_next = 1'b0;
            end
            if (iss_hit) begin
               pend_next = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               data_reg <= '0;
               pend_reg <= 1'b0;
            end else begin
               if (wr_hit) begin
                  data_reg <= wr_val;
               end
               pend_reg <= pend_next;
            end
         end

         assign mem_words[gi] = data_reg;
         assign pend_all[gi]  = pend_reg;
      end
   endgenerate

   // -----------------------------------------------------------------------
   // Read ports
   // -----------------------------------------------------------------------
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] rd_val;

         assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

         always_comb begin
            rd_val = mem_words[addr];
            if (BYPASS != 0) begin
               for (int j = 0; j < NUM_WR; j++) begin
                  if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == addr)) begin
                     rd_val = wr_data[j*DATA_W +: DATA_W];
                  end
               end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
               rd_val = '0;
            end
            // Storage is already cleared in reset; this also blocks
            // forwarded write data from leaking out while reset is held.
            if (!rst_n) begin
               rd_val = '0;
            end
         end

         assign rd_data[gi*DATA_W +: DATA_W] = rd_val;
         // Registered bit only: a write in flight this cycle does not hide it.
         assign rd_pending[gi] = pend_all[addr];
      end
   endgenerate

   assign busy_any = |pend_all;

endmodule
